// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter sharing one ALU: accept one request, issue it, wait out the
// ALU latency, return the tagged result. Define ALU_ARB_FIXED_PRIO_EN to give req0 fixed priority.
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_mode,
    input  logic [1:0]         req_cin,
    input  logic [3:0]         req_inp_valid,
    input  logic [7:0]         req_cmd,
    input  logic [2*WIDTH-1:0] req_opa,
    input  logic [2*WIDTH-1:0] req_opb,
    output logic               alu_ce,
    output logic               alu_cin,
    output logic               alu_mode,
    output logic [1:0]         alu_inp_valid,
    output logic [3:0]         alu_cmd,
    output logic [WIDTH-1:0]   alu_opa,
    output logic [WIDTH-1:0]   alu_opb,
    input  logic [WIDTH:0]     alu_res,
    input  logic [5:0]         alu_flags,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH:0]     rsp_res,
    output logic [5:0]         rsp_flags
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             owner_q;
    logic             alu_ce_q;
    logic             alu_cin_q;
    logic             alu_mode_q;
    logic [1:0]       alu_inp_valid_q;
    logic [3:0]       alu_cmd_q;
    logic [WIDTH-1:0] alu_opa_q;
    logic [WIDTH-1:0] alu_opb_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH:0]   rsp_res_q;
    logic [5:0]       rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             rr_q;
`endif

    logic             sel_d;
    logic             accept;
    logic             is_mul;
    logic             sel_mode;
    logic             sel_cin;
    logic [1:0]       sel_inp_valid;
    logic [3:0]       sel_cmd;
    logic [WIDTH-1:0] sel_opa;
    logic [WIDTH-1:0] sel_opb;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_d = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        sel_d = (req_valid == 2'b10);
`else
        if (req_valid == 2'b10) begin
            sel_d = 1'b1;
        end else if (req_valid == 2'b11) begin
            sel_d = rr_q;
        end
`endif
        req_ready = 2'b00;
        if (state_q == S_IDLE && !rst && req_valid != 2'b00) begin
            req_ready = sel_d ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);

        sel_mode      = req_mode[sel_d];
        sel_cin       = req_cin[sel_d];
        sel_inp_valid = sel_d ? req_inp_valid[3:2] : req_inp_valid[1:0];
        sel_cmd       = sel_d ? req_cmd[7:4] : req_cmd[3:0];
        sel_opa       = sel_d ? req_opa[2*WIDTH-1:WIDTH] : req_opa[WIDTH-1:0];
        sel_opb       = sel_d ? req_opb[2*WIDTH-1:WIDTH] : req_opb[WIDTH-1:0];
    end

    // Multiply commands take the longer ALU path; decided from the latched command.
    assign is_mul = alu_mode_q && (alu_cmd_q == 4'd9 || alu_cmd_q == 4'd10);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            owner_q         <= 1'b0;
            alu_ce_q        <= 1'b0;
            alu_cin_q       <= 1'b0;
            alu_mode_q      <= 1'b0;
            alu_inp_valid_q <= 2'b00;
            alu_cmd_q       <= 4'd0;
            alu_opa_q       <= '0;
            alu_opb_q       <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= 1'b0;
            rsp_res_q       <= '0;
            rsp_flags_q     <= 6'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q            <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q         <= S_ISSUE;
                        owner_q         <= sel_d;
                        alu_ce_q        <= 1'b1;
                        alu_cin_q       <= sel_cin;
                        alu_mode_q      <= sel_mode;
                        alu_inp_valid_q <= sel_inp_valid;
                        alu_cmd_q       <= sel_cmd;
                        alu_opa_q       <= sel_opa;
                        alu_opb_q       <= sel_opb;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_q            <= ~sel_d;
`endif
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= is_mul ? CW'(MUL_LAT) : CW'(LAT);
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q         <= S_RESP;
                        alu_ce_q        <= 1'b0;
                        alu_inp_valid_q <= 2'b00;
                        rsp_valid_q     <= 1'b1;
                        rsp_id_q        <= owner_q;
                        rsp_res_q       <= alu_res;
                        rsp_flags_q     <= alu_flags;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_ce        = alu_ce_q;
    assign alu_cin       = alu_cin_q;
    assign alu_mode      = alu_mode_q;
    assign alu_inp_valid = alu_inp_valid_q;
    assign alu_cmd       = alu_cmd_q;
    assign alu_opa       = alu_opa_q;
    assign alu_opb       = alu_opb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_res       = rsp_res_q;
    assign rsp_flags     = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed cases then random traffic against a grant/result model.
// Honours ALU_ARB_FIXED_PRIO_EN the same way as the design.
module tb_alu_req_arbiter;

    localparam int LAT     = 1;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_mode;
    logic [1:0]  req_cin;
    logic [3:0]  req_inp_valid;
    logic [7:0]  req_cmd;
    logic [15:0] req_opa;
    logic [15:0] req_opb;
    logic        alu_ce;
    logic        alu_cin;
    logic        alu_mode;
    logic [1:0]  alu_inp_valid;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_opa;
    logic [7:0]  alu_opb;
    logic [8:0]  alu_res;
    logic [5:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [8:0]  rsp_res;
    logic [5:0]  rsp_flags;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic last_grant = 1'b1;

    alu_req_arbiter #(.WIDTH(8), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_cin(req_cin), .req_inp_valid(req_inp_valid), .req_cmd(req_cmd),
        .req_opa(req_opa), .req_opb(req_opb),
        .alu_ce(alu_ce), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .alu_inp_valid(alu_inp_valid), .alu_cmd(alu_cmd),
        .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_res(alu_res), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags[5:0], res[8:0]} with flags = {err,oflow,cout,g,l,e}.
    function automatic logic [14:0] alu_f(input logic mode, input logic cin, input logic [1:0] iv,
                                          input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        int         x;
        logic [5:0] f;
        x = 0;
        f = 6'd0;
        if (iv != 2'b11) begin
            f[5] = 1'b1;
        end else if (mode) begin
            case (cmd)
                4'd0:    x = a + b;
                4'd1:    x = a - b;
                4'd2:    x = a + b + cin;
                4'd8:    f[2:0] = {a > b, a < b, a == b};
                4'd9:    x = (a + 1) * (b + 1);
                4'd10:   x = (a * 2) * b;
                default: f[5] = 1'b1;
            endcase
            if (cmd <= 4'd2) f[3] = x[8];
        end else begin
            case (cmd)
                4'd0:    x = a & b;
                4'd1:    x = a | b;
                4'd2:    x = a ^ b;
                default: x = 255 - a;
            endcase
        end
        return {f, x[8:0]};
    endfunction

    always_comb begin
        {alu_flags, alu_res} = 15'd0;
        if (alu_ce) {alu_flags, alu_res} = alu_f(alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb);
    end

    // Grant rule: a lone requester wins; under contention the one not granted last wins.
    function automatic logic pick(input logic [1:0] v);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~last_grant;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {req_ready, alu_ce, alu_cin, alu_mode, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
                    rsp_valid, rsp_id, rsp_res, rsp_flags}, 64'd0);
    endtask

    function automatic logic [3:0] rand_cmd();
        if ($urandom_range(0, 3) == 0) return 4'(9 + $urandom_range(0, 1));
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [1:0] rand_iv();
        if ($urandom_range(0, 3) != 0) return 2'b11;
        return 2'($urandom_range(0, 3));
    endfunction

    // One transaction, entered and left at a negedge with the DUT idle.
    task automatic do_txn(input logic [1:0] vld, input logic [1:0] mode, input logic [1:0] cin,
                          input logic [3:0] iv, input logic [7:0] cmd, input logic [15:0] opa,
                          input logic [15:0] opb, input int hold,
                          output logic obs_id, output logic [8:0] obs_res);
        logic        w, m, c;
        logic [1:0]  v;
        logic [3:0]  k;
        logic [7:0]  a, b;
        logic [14:0] exp_rf;
        int          exp_lat, n;
        req_valid = vld; req_mode = mode; req_cin = cin; req_inp_valid = iv;
        req_cmd = cmd; req_opa = opa; req_opb = opb; rsp_ready = (hold == 0);
        #1;
        w = pick(vld);
        check("req_ready", req_ready, w ? 2'b10 : 2'b01);
        m = mode[w]; c = cin[w];
        v = w ? iv[3:2] : iv[1:0];
        k = w ? cmd[7:4] : cmd[3:0];
        a = w ? opa[15:8] : opa[7:0];
        b = w ? opb[15:8] : opb[7:0];
        exp_rf  = alu_f(m, c, v, k, a, b);
        exp_lat = (m && (k == 4'd9 || k == 4'd10)) ? MUL_LAT + 2 : LAT + 2;
        @(posedge clk);
        last_grant = w;
        @(negedge clk);
        req_mode = 2'($urandom); req_cin = 2'($urandom); req_inp_valid = 4'($urandom);
        req_cmd = 8'($urandom); req_opa = 16'($urandom); req_opb = 16'($urandom);
        check("alu_issue", {alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb},
              {1'b1, m, c, v, k, a, b});
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!rsp_valid)
                check("alu_hold", {alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb},
                      {1'b1, m, c, v, k, a, b});
        end while (!rsp_valid && n < 20);
        check("latency", n, exp_lat);
        check("rsp_id", rsp_id, w);
        check("rsp_res", rsp_res, exp_rf[8:0]);
        check("rsp_flags", rsp_flags, exp_rf[14:9]);
        obs_id  = rsp_id;
        obs_res = rsp_res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rsp_stall", {rsp_valid, rsp_id, rsp_res, rsp_flags, req_ready, alu_ce, alu_inp_valid},
                  {1'b1, w, exp_rf[8:0], exp_rf[14:9], 2'b00, 1'b0, 2'b00});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rsp_drop", rsp_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1);
    end

    initial begin
        logic       id;
        logic [8:0] res;
        logic [3:0] order;
        int         seen;

        rst = 1'b1; req_valid = 2'b00; req_mode = 2'b00; req_cin = 2'b00; req_inp_valid = 4'h0;
        req_cmd = 8'h00; req_opa = 16'h0; req_opb = 16'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b0;
        last_grant = 1'b1;

        // req0 add 5+3
        do_txn(2'b01, 2'b01, 2'b00, 4'b0011, 8'h00, 16'h0005, 16'h0003, 0, id, res);
        check("t_add_res", res, 9'h008);
        check("t_add_id", id, 1'b0);

        // req1 multiply (3+1)*(4+1)
        do_txn(2'b10, 2'b10, 2'b00, 4'b1100, 8'h90, 16'h0300, 16'h0400, 0, id, res);
        check("t_mul_res", res, 9'h014);
        check("t_mul_id", id, 1'b1);

        // response back-pressure for 5 cycles, sub 0x20-0x07
        do_txn(2'b01, 2'b01, 2'b00, 4'b0011, 8'h01, 16'h0020, 16'h0007, 5, id, res);
        check("t_stall_res", res, 9'h019);

        // reset during WAIT discards the op and clears the round-robin pointer
        req_valid = 2'b01; req_mode = 2'b01; req_inp_valid = 4'b0011; req_cmd = 8'h00;
        req_opa = 16'h0011; req_opb = 16'h0022; rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_grant = 1'b1;
        check_zero("rst_mid_outputs");
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        check("rst_mid_no_rsp", seen, 0);

        // sustained contention
        order = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, 2'($urandom), 2'($urandom), {rand_iv(), rand_iv()},
                   {rand_cmd(), rand_cmd()}, 16'($urandom), 16'($urandom), 0, id, res);
            order = {order[2:0], id};
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("grant_order", order, 4'b0000);
`else
        check("grant_order", order, 4'b0101);
`endif

        // random traffic
        for (int i = 0; i < 40; i++) begin
            do_txn(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), {rand_iv(), rand_iv()},
                   {rand_cmd(), rand_cmd()}, 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), id, res);
        end

        req_valid = 2'b00;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
